// File: rtl/graphite_fb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// graphite_fb_pkg : shared types and helpers for the frame-buffer swapper (rev 1.0)
// ---------------------------------------------------------------
package graphite_fb_pkg;

   localparam int MAX_BUFFERS = 4;

   typedef logic [1:0] fb_idx_t;

   // Byte address of buffer idx; the 32-bit result wraps silently.
   function automatic logic [31:0] fb_addr(input logic [31:0] base,
                                           input fb_idx_t     idx,
                                           input logic [31:0] size);
      return base + size * {30'd0, idx};
   endfunction

endpackage
`default_nettype wire

// File: rtl/graphite_fb_swap_if.sv
`default_nettype none
// ---------------------------------------------------------------
// graphite_fb_swap_if : rasteriser/scan-out side signals of the swapper (rev 1.0)
// ---------------------------------------------------------------
interface graphite_fb_swap_if;
   logic        ce_i;
   logic        swap_req_i;
   logic        vsync_i;
   logic [31:0] front_addr_o;
   logic [31:0] back_addr_o;
   logic        stall_o;
   logic        swap_done_o;
   logic [15:0] drop_cnt_o;
   logic        err_o;

   modport master (
      output ce_i, swap_req_i, vsync_i,
      input  front_addr_o, back_addr_o, stall_o, swap_done_o, drop_cnt_o, err_o
   );

   modport slave (
      input  ce_i, swap_req_i, vsync_i,
      output front_addr_o, back_addr_o, stall_o, swap_done_o, drop_cnt_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/graphite_idx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------
// graphite_idx_fifo : small shift FIFO of buffer indices with preloadable reset contents (rev 1.0)
// ---------------------------------------------------------------
module graphite_idx_fifo
   import graphite_fb_pkg::*;
#(
   parameter int                           DEPTH      = 2,
   parameter int                           INIT_COUNT = 0,
   parameter logic [2*MAX_BUFFERS-1:0]     INIT_DATA  = '0
) (
   input  logic    clk,
   input  logic    reset_ni,
   input  logic    push_i,
   input  fb_idx_t push_data_i,
   input  logic    pop_i,
   output fb_idx_t head_o,
   output logic    empty_o,
   output logic    full_o
);

   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_ONE   = CW'(1);

   fb_idx_t       mem_q [DEPTH];
   fb_idx_t       mem_d [DEPTH];
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Pop is applied before push so a simultaneous pair works even when full.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (pop_i && (count_q != '0)) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         count_d = count_q - C_ONE;
      end
      if (push_i && (count_d < C_DEPTH)) begin
         mem_d[count_d] = push_data_i;
         count_d        = count_d + C_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= INIT_DATA[2*i +: 2];
         end
         count_q <= CW'(INIT_COUNT);
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[0];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/graphite_fb_swap.sv
`default_nettype none
// ---------------------------------------------------------------
// graphite_fb_swap : double/triple/quad frame-buffer rotation, FIFO or mailbox presentation (rev 1.0)
// ---------------------------------------------------------------
module graphite_fb_swap
   import graphite_fb_pkg::*;
#(
   parameter int          FB_WIDTH    = 320,
   parameter int          FB_HEIGHT   = 240,
   parameter int          BPP_BYTES   = 2,
   parameter int          NUM_BUFFERS = 2,
   parameter logic [31:0] BASE_ADDR   = 32'd0,
   parameter bit          MAILBOX     = 1'b0
) (
   input  logic               clk,
   input  logic               reset_ni,
   graphite_fb_swap_if.slave  bus
);

   localparam logic [31:0]                FB_SIZE   = 32'(FB_WIDTH * FB_HEIGHT * BPP_BYTES);
   localparam logic [2*MAX_BUFFERS-1:0]   FREE_INIT = {2'd0, 2'd0, 2'd3, 2'd2};

   logic        vs_q, vs_d;
   fb_idx_t     front_idx_q, front_idx_d;
   fb_idx_t     back_idx_q, back_idx_d;
   logic        back_valid_q, back_valid_d;
   logic [31:0] front_addr_q, front_addr_d;
   logic [31:0] back_addr_q, back_addr_d;
   logic        stall_q, stall_d;
   logic        swap_done_q, swap_done_d;
   logic        err_q, err_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   logic    vs_evt, swap_req, swap_evt;
   logic    ready_push, ready_pop, ready_empty, ready_full;
   fb_idx_t ready_head;
   logic    free_push, free_pop, free_empty, free_full;
   fb_idx_t free_head, free_push_data;

   graphite_idx_fifo #(
      .DEPTH      (NUM_BUFFERS - 1),
      .INIT_COUNT (0),
      .INIT_DATA  ('0)
   ) u_ready (
      .clk         (clk),
      .reset_ni    (reset_ni),
      .push_i      (ready_push & (~ready_full | ready_pop)),
      .push_data_i (back_idx_q),
      .pop_i       (ready_pop),
      .head_o      (ready_head),
      .empty_o     (ready_empty),
      .full_o      (ready_full)
   );

   graphite_idx_fifo #(
      .DEPTH      (NUM_BUFFERS),
      .INIT_COUNT (NUM_BUFFERS - 2),
      .INIT_DATA  (FREE_INIT)
   ) u_free (
      .clk         (clk),
      .reset_ni    (reset_ni),
      .push_i      (free_push & ~free_full),
      .push_data_i (free_push_data),
      .pop_i       (free_pop),
      .head_o      (free_head),
      .empty_o     (free_empty),
      .full_o      (free_full)
   );

   always_comb begin
      vs_d         = bus.vsync_i;
      vs_evt       = bus.ce_i & bus.vsync_i & ~vs_q & ~ready_empty;
      swap_req     = bus.ce_i & bus.swap_req_i;
      swap_evt     = swap_req & back_valid_q;
      front_idx_d  = front_idx_q;
      back_idx_d   = back_idx_q;
      back_valid_d = back_valid_q;
      ready_push   = 1'b0;
      ready_pop    = 1'b0;
      free_push    = 1'b0;
      free_pop     = 1'b0;
      free_push_data = front_idx_q;
      drop_cnt_d   = drop_cnt_q;
      err_d        = err_q | (swap_req & ~back_valid_q);

      if (vs_evt) begin
         ready_pop   = 1'b1;
         front_idx_d = ready_head;
         if (!back_valid_q) begin
            back_idx_d   = front_idx_q;
            back_valid_d = 1'b1;
         end else begin
            free_push = 1'b1;
         end
      end

      if (swap_evt) begin
         // Mailbox keeps at most one ready frame, so a vsync pop this cycle leaves it empty.
         if (MAILBOX && !ready_empty && !vs_evt) begin
            ready_pop      = 1'b1;
            free_push      = 1'b1;
            free_push_data = ready_head;
            drop_cnt_d     = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
         end
         ready_push = 1'b1;
         if (!free_empty) begin
            free_pop   = 1'b1;
            back_idx_d = free_head;
         end else if (free_push) begin
            // The index just released would be the free head: hand it straight to back.
            free_push  = 1'b0;
            back_idx_d = free_push_data;
         end else begin
            back_valid_d = 1'b0;
         end
      end

      front_addr_d = fb_addr(BASE_ADDR, front_idx_d, FB_SIZE);
      back_addr_d  = back_valid_d ? fb_addr(BASE_ADDR, back_idx_d, FB_SIZE) : back_addr_q;
      stall_d      = ~back_valid_d;
      swap_done_d  = vs_evt;
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         vs_q         <= 1'b1;
         front_idx_q  <= 2'd0;
         back_idx_q   <= 2'd1;
         back_valid_q <= 1'b1;
         front_addr_q <= BASE_ADDR;
         back_addr_q  <= BASE_ADDR + FB_SIZE;
         stall_q      <= 1'b0;
         swap_done_q  <= 1'b0;
         err_q        <= 1'b0;
         drop_cnt_q   <= 16'd0;
      end else if (bus.ce_i) begin
         vs_q         <= vs_d;
         front_idx_q  <= front_idx_d;
         back_idx_q   <= back_idx_d;
         back_valid_q <= back_valid_d;
         front_addr_q <= front_addr_d;
         back_addr_q  <= back_addr_d;
         stall_q      <= stall_d;
         swap_done_q  <= swap_done_d;
         err_q        <= err_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign bus.front_addr_o = front_addr_q;
   assign bus.back_addr_o  = back_addr_q;
   assign bus.stall_o      = stall_q;
   assign bus.swap_done_o  = swap_done_q;
   assign bus.drop_cnt_o   = drop_cnt_q;
   assign bus.err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_graphite_fb_swap.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_graphite_fb_swap : three swapper configurations driven in lockstep against a queue model (rev 1.0)
// ---------------------------------------------------------------
module tb_graphite_fb_swap;
   import graphite_fb_pkg::*;

   localparam int          NI      = 3;
   localparam logic [31:0] FB_SIZE = 32'h0002_5800;
   localparam int          N_BUF [NI] = '{2, 3, 3};
   localparam int          MB    [NI] = '{0, 0, 1};

   typedef struct packed {
      logic [31:0] front;
      logic [31:0] back;
      logic        stall;
      logic        done;
      logic        err;
      logic [15:0] drop;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ce    = 1'b0;
   logic sw    = 1'b0;
   logic vs    = 1'b0;

   logic [31:0] o_front [NI];
   logic [31:0] o_back  [NI];
   logic        o_stall [NI];
   logic        o_done  [NI];
   logic        o_err   [NI];
   logic [15:0] o_drop  [NI];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      graphite_fb_swap_if bus ();
      assign bus.ce_i       = ce;
      assign bus.swap_req_i = sw;
      assign bus.vsync_i    = vs;
      graphite_fb_swap #(
         .NUM_BUFFERS (N_BUF[k]),
         .MAILBOX     (MB[k] != 0)
      ) u_dut (
         .clk      (clk),
         .reset_ni (rst_n),
         .bus      (bus)
      );
      assign o_front[k] = bus.front_addr_o;
      assign o_back[k]  = bus.back_addr_o;
      assign o_stall[k] = bus.stall_o;
      assign o_done[k]  = bus.swap_done_o;
      assign o_err[k]   = bus.err_o;
      assign o_drop[k]  = bus.drop_cnt_o;
   end

   int n_cmp = 0;
   int n_bad = 0;

   int          m_front [NI];
   int          m_back  [NI];
   int          m_valid [NI];
   int          m_err   [NI];
   int          m_done  [NI];
   int          m_vsq   [NI];
   int          m_drop  [NI];
   logic [31:0] m_baddr [NI];
   int          m_ready [NI][$];
   int          m_free  [NI][$];
   exp_t        sb_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] addr_of(input int i);
      return 32'(i) * FB_SIZE;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_front[k] = 0;
         m_back[k]  = 1;
         m_valid[k] = 1;
         m_err[k]   = 0;
         m_done[k]  = 0;
         m_vsq[k]   = 1;
         m_drop[k]  = 0;
         m_baddr[k] = addr_of(1);
         m_ready[k].delete();
         m_free[k].delete();
         for (int b = 2; b < N_BUF[k]; b++) m_free[k].push_back(b);
      end
      sb_q.delete();
   endtask

   // One clock: vsync handling first, then the swap, as the presentation rules order them.
   task automatic step(input logic c, input logic s, input logic v);
      exp_t e;
      bit   rise;
      bit   was_valid;
      int   old;
      ce = c;
      sw = s;
      vs = v;
      for (int k = 0; k < NI; k++) begin
         if (c) begin
            rise      = v && (m_vsq[k] == 0);
            was_valid = (m_valid[k] != 0);
            m_vsq[k]  = int'(v);
            m_done[k] = 0;
            if (s && !was_valid) m_err[k] = 1;
            if (rise && m_ready[k].size() > 0) begin
               old        = m_front[k];
               m_front[k] = m_ready[k].pop_front();
               m_done[k]  = 1;
               if (!was_valid) begin
                  m_back[k]  = old;
                  m_valid[k] = 1;
               end else begin
                  m_free[k].push_back(old);
               end
            end
            if (s && was_valid) begin
               if (MB[k] != 0 && m_ready[k].size() > 0) begin
                  m_free[k].push_back(m_ready[k].pop_front());
                  if (m_drop[k] < 16'hFFFF) m_drop[k]++;
               end
               m_ready[k].push_back(m_back[k]);
               if (m_free[k].size() > 0) m_back[k] = m_free[k].pop_front();
               else m_valid[k] = 0;
            end
            if (m_valid[k] != 0) m_baddr[k] = addr_of(m_back[k]);
         end
         e.front = addr_of(m_front[k]);
         e.back  = m_baddr[k];
         e.stall = (m_valid[k] == 0);
         e.done  = (m_done[k] != 0);
         e.err   = (m_err[k] != 0);
         e.drop  = 16'(m_drop[k]);
         sb_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         e = sb_q.pop_front();
         check($sformatf("u%0d.front", k), o_front[k], e.front);
         check($sformatf("u%0d.back", k), o_back[k], e.back);
         check($sformatf("u%0d.stall", k), 32'(o_stall[k]), 32'(e.stall));
         check($sformatf("u%0d.done", k), 32'(o_done[k]), 32'(e.done));
         check($sformatf("u%0d.err", k), 32'(o_err[k]), 32'(e.err));
         check($sformatf("u%0d.drop", k), 32'(o_drop[k]), 32'(e.drop));
         if (o_stall[k] == 1'b0)
            check($sformatf("u%0d.front_eq_back", k), 32'(o_front[k] == o_back[k]), 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s.u%0d.front", tag, k), o_front[k], 32'h0);
         check($sformatf("%s.u%0d.back", tag, k), o_back[k], 32'h0002_5800);
         check($sformatf("%s.u%0d.stall", tag, k), 32'(o_stall[k]), 32'd0);
         check($sformatf("%s.u%0d.done", tag, k), 32'(o_done[k]), 32'd0);
         check($sformatf("%s.u%0d.err", tag, k), 32'(o_err[k]), 32'd0);
         check($sformatf("%s.u%0d.drop", tag, k), 32'(o_drop[k]), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit rc, rs, rv;
      model_reset();
      rst_n = 1'b0;
      vs    = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("rst");

      // vsync high since reset is not an edge
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);

      step(1'b1, 1'b1, 1'b0);
      check("u0.stall_after_swap", 32'(o_stall[0]), 32'd1);
      check("u1.stall_after_swap1", 32'(o_stall[1]), 32'd0);

      step(1'b1, 1'b1, 1'b0);
      check("u0.err_swap_stalled", 32'(o_err[0]), 32'd1);
      check("u0.back_held", o_back[0], 32'h0002_5800);
      check("u1.stall_after_swap2", 32'(o_stall[1]), 32'd1);
      check("u2.stall_mailbox", 32'(o_stall[2]), 32'd0);
      check("u2.drop_one", 32'(o_drop[2]), 32'd1);

      step(1'b1, 1'b0, 1'b1);
      check("u0.front_vs1", o_front[0], 32'h0002_5800);
      check("u0.back_vs1", o_back[0], 32'h0);
      check("u0.done_vs1", 32'(o_done[0]), 32'd1);
      check("u0.err_sticky", 32'(o_err[0]), 32'd1);
      check("u1.front_vs1", o_front[1], 32'h0002_5800);
      check("u2.front_newest", o_front[2], 32'h0004_B000);

      step(1'b1, 1'b0, 1'b0);
      check("u1.done_cleared", 32'(o_done[1]), 32'd0);
      step(1'b1, 1'b0, 1'b1);
      check("u1.front_vs2", o_front[1], 32'h0004_B000);
      check("u1.done_vs2", 32'(o_done[1]), 32'd1);
      check("u1.drop_fifo", 32'(o_drop[1]), 32'd0);
      check("u0.no_done_empty", 32'(o_done[0]), 32'd0);
      step(1'b1, 1'b0, 1'b0);

      // clock enable low: pulses are dropped
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      check("u1.front_simul", o_front[1], 32'h0);
      check("u1.back_simul", o_back[1], 32'h0004_B000);
      check("u1.stall_simul", 32'(o_stall[1]), 32'd0);
      step(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         rc = ($urandom_range(0, 7) != 0);
         rs = ($urandom_range(0, 2) == 0);
         rv = ($urandom_range(0, 1) == 1);
         step(rc, rs, rv);
      end

      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("u0.stall_before_rst", 32'(o_stall[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("u0.ready_discarded", 32'(o_done[0]), 32'd0);
      check("u0.front_after_rst", o_front[0], 32'h0);
      step(1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
